pc_gen: RTL and testbench

Parametrised program-counter generator for the openMIPS fetch stage. It replaces the fixed-width, increment-only PC with one that supports a configurable reset vector, increment, and address width. It accepts branch redirects from decode and flush redirects from the exception logic. A branch that arrives while fetch is stalled is held and applied when the stall releases. It drives the instruction-memory address and chip enable.

---
 rtl/pc_gen_pkg.sv | 22 ++
 rtl/pc_gen_if.sv | 27 ++
 rtl/pc_redirect_buf.sv | 30 +++
 rtl/pc_gen.sv | 95 +++++++++
 tb/tb_pc_gen.sv | 120 ++++++++++++
 5 files changed

// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: shared fetch-stage constants and the pc_gen state encoding
package pc_gen_pkg;

    localparam logic RstEnable   = 1'b1;
    localparam logic ChipEnable  = 1'b1;
    localparam logic ChipDisable = 1'b0;
    localparam logic Stop        = 1'b1;
    localparam logic NoStop      = 1'b0;
    localparam int   InstAddrBus = 32;

    typedef enum logic [1:0] {
        ST_DIS  = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } pc_state_t;

    // The state is never stored on its own; it is implied by ce and the pending flag.
    function automatic pc_state_t decode_state(input logic ce, input logic pend);
        return (ce == ChipDisable) ? ST_DIS : (pend ? ST_PEND : ST_RUN);
    endfunction

endpackage

// File: rtl/pc_gen_if.sv
// pc_gen_if: redirect/stall inputs and fetch-address outputs of the PC generator
interface pc_gen_if #(
    parameter int ADDR_W  = 32,
    parameter int STALL_W = 6
);

    logic [STALL_W-1:0] stall;
    logic               branch_flag_i;
    logic [ADDR_W-1:0]  branch_target_i;
    logic               flush;
    logic [ADDR_W-1:0]  new_pc;
    logic               ce;
    logic [ADDR_W-1:0]  pc;
    logic               pc_misalign_o;
    logic               redirect_pend_o;

    modport master (
        output stall, branch_flag_i, branch_target_i, flush, new_pc,
        input  ce, pc, pc_misalign_o, redirect_pend_o
    );

    modport slave (
        input  stall, branch_flag_i, branch_target_i, flush, new_pc,
        output ce, pc, pc_misalign_o, redirect_pend_o
    );

endinterface

// File: rtl/pc_redirect_buf.sv
// pc_redirect_buf: holds a branch target that arrived while fetch was stalled
module pc_redirect_buf #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              i_capture,
    input  logic              i_overwrite,
    input  logic              i_consume,
    input  logic              i_clear,
    input  logic [ADDR_W-1:0] i_target,
    output logic              o_valid,
    output logic [ADDR_W-1:0] o_target
);

    logic              r_valid;
    logic [ADDR_W-1:0] r_target;

    always_ff @(posedge clk) begin
        if (i_clear || i_consume) begin
            r_valid <= 1'b0;
        end else if (i_capture || i_overwrite) begin
            r_valid  <= 1'b1;
            r_target <= i_target;
        end
    end

    assign o_valid  = r_valid;
    assign o_target = r_target;

endmodule

// File: rtl/pc_gen.sv
// pc_gen: parametrised fetch PC with branch/flush redirects and stalled-branch holding
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int                ADDR_W    = InstAddrBus,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0,
    parameter int                INC       = 4,
    parameter int                STALL_W   = 6
) (
    input  logic     clk,
    input  logic     rst,
    pc_gen_if.slave  bus
);

    logic              r_ce;
    logic [ADDR_W-1:0] r_pc;
    logic              r_misalign;
    pc_state_t         w_state;
    logic [ADDR_W-1:0] w_pc_next;
    logic              w_stop;
    logic              w_capture;
    logic              w_overwrite;
    logic              w_consume;
    logic              w_clear;
    logic              w_pend;
    logic [ADDR_W-1:0] w_pend_target;
    logic              w_unused_stall;

    assign w_stop         = (bus.stall[0] == Stop);
    assign w_unused_stall = ^bus.stall;

    pc_redirect_buf #(.ADDR_W(ADDR_W)) u_buf (
        .clk         (clk),
        .i_capture   (w_capture),
        .i_overwrite (w_overwrite),
        .i_consume   (w_consume),
        .i_clear     (w_clear),
        .i_target    (bus.branch_target_i),
        .o_valid     (w_pend),
        .o_target    (w_pend_target)
    );

    always_comb begin
        w_state     = decode_state(r_ce, w_pend);
        w_pc_next   = r_pc;
        w_capture   = 1'b0;
        w_overwrite = 1'b0;
        w_consume   = 1'b0;
        w_clear     = 1'b0;
        case (w_state)
            ST_DIS: begin
                w_pc_next = RESET_VEC;
                w_clear   = 1'b1;
            end
            ST_RUN: begin
                if (bus.flush)
                    w_pc_next = bus.new_pc;
                else if (bus.branch_flag_i && !w_stop)
                    w_pc_next = bus.branch_target_i;
                else if (bus.branch_flag_i)
                    w_capture = 1'b1;
                else if (!w_stop)
                    w_pc_next = r_pc + ADDR_W'(INC);
            end
            ST_PEND: begin
                if (bus.flush) begin
                    w_pc_next = bus.new_pc;
                    w_clear   = 1'b1;
                end else if (w_stop) begin
                    w_overwrite = bus.branch_flag_i;
                end else begin
                    // A fresh branch on the release cycle is younger than the held one.
                    w_pc_next = bus.branch_flag_i ? bus.branch_target_i : w_pend_target;
                    w_consume = 1'b1;
                end
            end
            default: begin
                w_pc_next = RESET_VEC;
                w_clear   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        r_ce       <= (rst == RstEnable) ? ChipDisable : ChipEnable;
        r_pc       <= w_pc_next;
        r_misalign <= |w_pc_next[1:0];
    end

    assign bus.ce              = r_ce;
    assign bus.pc              = r_pc;
    assign bus.pc_misalign_o   = r_misalign;
    assign bus.redirect_pend_o = w_pend;

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed vectors for pc_gen with hand-computed PC sequences
module tb_pc_gen;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    pc_gen_if #(.ADDR_W(32), .STALL_W(6)) bus ();

    pc_gen #(
        .ADDR_W    (32),
        .RESET_VEC (32'hBFC0_0000),
        .INC       (4),
        .STALL_W   (6)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        bus.stall = '0;
        bus.branch_flag_i = 1'b0;
        bus.branch_target_i = '0;
        bus.flush = 1'b0;
        bus.new_pc = '0;
        tick; tick; tick;
        chk("rst_ce", {31'd0, bus.ce}, 32'd0);
        chk("rst_pc", bus.pc, 32'hBFC0_0000);
        chk("rst_mis", {31'd0, bus.pc_misalign_o}, 32'd0);
        chk("rst_pend", {31'd0, bus.redirect_pend_o}, 32'd0);
        rst = 1'b0;
        tick;
        chk("first_ce", {31'd0, bus.ce}, 32'd1);
        chk("first_pc", bus.pc, 32'hBFC0_0000);
        tick; chk("inc1", bus.pc, 32'hBFC0_0004);
        tick; chk("inc2", bus.pc, 32'hBFC0_0008);
        // stall freezes the PC for exactly the stalled edges
        bus.flush = 1'b1; bus.new_pc = 32'h10;
        tick; chk("flush10", bus.pc, 32'h10);
        bus.flush = 1'b0; bus.stall = 6'b000001;
        tick; chk("stall_a", bus.pc, 32'h10);
        tick; chk("stall_b", bus.pc, 32'h10);
        bus.stall = '0;
        tick; chk("stall_rel", bus.pc, 32'h14);
        bus.flush = 1'b1; bus.new_pc = 32'h20;
        tick; chk("flush20", bus.pc, 32'h20);
        bus.flush = 1'b0; bus.branch_flag_i = 1'b1; bus.branch_target_i = 32'h400;
        tick; chk("br_pc", bus.pc, 32'h400);
        bus.branch_flag_i = 1'b0;
        tick; chk("br_inc", bus.pc, 32'h404);
        // branch under a three-cycle stall
        bus.stall = 6'b000001; bus.branch_flag_i = 1'b1; bus.branch_target_i = 32'h800;
        tick; chk("sb_pc1", bus.pc, 32'h404); chk("sb_pend1", {31'd0, bus.redirect_pend_o}, 32'd1);
        bus.branch_flag_i = 1'b0;
        tick; chk("sb_pc2", bus.pc, 32'h404);
        tick; chk("sb_pc3", bus.pc, 32'h404); chk("sb_pend3", {31'd0, bus.redirect_pend_o}, 32'd1);
        bus.stall = '0;
        tick; chk("sb_rel", bus.pc, 32'h800); chk("sb_pend0", {31'd0, bus.redirect_pend_o}, 32'd0);
        tick; chk("sb_inc", bus.pc, 32'h804);
        bus.stall = 6'b000001; bus.branch_flag_i = 1'b1; bus.branch_target_i = 32'h800;
        tick; chk("ow_pend", {31'd0, bus.redirect_pend_o}, 32'd1);
        bus.branch_target_i = 32'h900;
        tick; chk("ow_hold", bus.pc, 32'h804);
        bus.branch_flag_i = 1'b0; bus.stall = '0;
        tick; chk("ow_rel", bus.pc, 32'h900); chk("ow_pend0", {31'd0, bus.redirect_pend_o}, 32'd0);
        // flush discards a held branch even while stalled
        bus.stall = 6'b000001; bus.branch_flag_i = 1'b1; bus.branch_target_i = 32'h800;
        tick; chk("fp_pend", {31'd0, bus.redirect_pend_o}, 32'd1); chk("fp_hold", bus.pc, 32'h900);
        bus.branch_flag_i = 1'b0; bus.flush = 1'b1; bus.new_pc = 32'h180;
        tick; chk("fp_pc", bus.pc, 32'h180); chk("fp_pend0", {31'd0, bus.redirect_pend_o}, 32'd0);
        bus.flush = 1'b0;
        tick; chk("fp_stall", bus.pc, 32'h180);
        bus.stall = '0;
        tick; chk("fp_inc", bus.pc, 32'h184);
        bus.stall = 6'b000001; bus.branch_flag_i = 1'b1; bus.branch_target_i = 32'h800;
        tick; chk("nb_pend", {31'd0, bus.redirect_pend_o}, 32'd1);
        bus.stall = '0; bus.branch_target_i = 32'hA00;
        tick; chk("nb_rel", bus.pc, 32'hA00);
        bus.branch_flag_i = 1'b0;
        bus.flush = 1'b1; bus.new_pc = 32'hFFFF_FFFC;
        tick; chk("wrap_pre", bus.pc, 32'hFFFF_FFFC);
        bus.flush = 1'b0;
        tick; chk("wrap", bus.pc, 32'h0);
        bus.branch_flag_i = 1'b1; bus.branch_target_i = 32'h402;
        tick; chk("mis_pc", bus.pc, 32'h402); chk("mis_flag", {31'd0, bus.pc_misalign_o}, 32'd1);
        bus.branch_flag_i = 1'b0;
        tick; chk("mis_inc", bus.pc, 32'h406); chk("mis_flag2", {31'd0, bus.pc_misalign_o}, 32'd1);
        // reset while a branch is held loses it
        bus.stall = 6'b000001; bus.branch_flag_i = 1'b1; bus.branch_target_i = 32'h800;
        tick; chk("rp_pend", {31'd0, bus.redirect_pend_o}, 32'd1);
        bus.branch_flag_i = 1'b0; rst = 1'b1;
        tick; chk("rp_ce", {31'd0, bus.ce}, 32'd0); chk("rp_pc", bus.pc, 32'h406);
        tick; chk("rp_pc2", bus.pc, 32'hBFC0_0000); chk("rp_pend0", {31'd0, bus.redirect_pend_o}, 32'd0);
        chk("rp_mis0", {31'd0, bus.pc_misalign_o}, 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
